// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: shadow scoreboard, stall/flush strobes,
// EX operand forwarding and a memory-wait FSM. Define HAZARD_STATS_EN to add statistics counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] rs_addrD,
    input  logic [4:0] rt_addrD,
    input  logic       useRsD,
    input  logic       useRtD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic       MemAccessD,
    input  logic [4:0] dest_addrD,
    input  logic       JumpD,
    input  logic       BranchTakenE,
    input  logic       mem_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       err_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        logic       memaccess;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
    } entry_t;

    localparam int     ENT_W     = $bits(entry_t);
    localparam entry_t EMPTY_ENT = entry_t'({ENT_W{1'b0}});

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // An entry supplies a value for addr only if it is live, writes, and is not r0.
    function automatic logic writes_reg(input entry_t ent, input logic [4:0] addr);
        return ent.valid && ent.regwrite && (ent.dest != 5'd0) && (ent.dest == addr);
    endfunction

    function automatic logic [1:0] fwd_sel(input entry_t ent_m, input entry_t ent_w,
                                           input logic [4:0] addr);
        logic [1:0] sel;
        if (writes_reg(ent_m, addr)) begin
            sel = 2'b10;
        end else if (writes_reg(ent_w, addr)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Source operands are only meaningful while the instruction sits in EX.
    function automatic entry_t retire_operands(input entry_t ent);
        entry_t out_ent;
        out_ent    = ent;
        out_ent.rs = 5'd0;
        out_ent.rt = 5'd0;
        return out_ent;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    entry_t            ent_e_r;
    entry_t            ent_m_r;
    entry_t            ent_w_r;
    entry_t            id_ent_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              err_r;
    logic              mem_stall_s;
    logic              load_use_s;
    logic              stall_f_s;
    logic              stall_d_s;
    logic              stall_e_s;
    logic              stall_m_s;
    logic              flush_d_s;
    logic              flush_e_s;
    logic              flush_w_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;
    logic              unused_w_fields_s;

    assign unused_w_fields_s = ^{ent_w_r.memtoreg, ent_w_r.memaccess, ent_w_r.rs, ent_w_r.rt};

    // The stall starts on the first cycle the access is pending, before the FSM has entered MEM_WAIT.
    assign mem_stall_s = !mem_ready && ((state_r == MEM_WAIT) || (ent_m_r.valid && ent_m_r.memaccess));

    assign load_use_s = ent_e_r.valid && ent_e_r.memtoreg && (ent_e_r.dest != 5'd0) &&
                        ((useRsD && (rs_addrD == ent_e_r.dest)) ||
                         (useRtD && (rt_addrD == ent_e_r.dest)));

    assign fwd_a_s = fwd_sel(ent_m_r, ent_w_r, ent_e_r.rs);
    assign fwd_b_s = fwd_sel(ent_m_r, ent_w_r, ent_e_r.rt);

    // Decoded ID instruction as it would enter the EX scoreboard slot.
    always_comb begin
        id_ent_s           = EMPTY_ENT;
        id_ent_s.valid     = 1'b1;
        id_ent_s.regwrite  = RegWriteD;
        id_ent_s.memtoreg  = MemtoRegD;
        id_ent_s.memaccess = MemAccessD;
        id_ent_s.dest      = dest_addrD;
        id_ent_s.rs        = rs_addrD;
        id_ent_s.rt        = rt_addrD;
    end

    // Memory-wait FSM next state and prioritised stall/flush strobes.
    always_comb begin
        state_nxt_s = state_r;
        stall_f_s   = 1'b0;
        stall_d_s   = 1'b0;
        stall_e_s   = 1'b0;
        stall_m_s   = 1'b0;
        flush_d_s   = 1'b0;
        flush_e_s   = 1'b0;
        flush_w_s   = 1'b0;

        case (state_r)
            RUN: begin
                if (ent_m_r.valid && ent_m_r.memaccess && !mem_ready) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = MEM_WAIT;
                end
            end
            default: state_nxt_s = RUN;
        endcase

        // A taken branch bubbles EX anyway, so it overrides a coincident load-use stall.
        if (mem_stall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (BranchTakenE) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (load_use_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (JumpD) begin
            flush_d_s = 1'b1;
        end else begin
            flush_d_s = 1'b0;
        end
    end

    // Scoreboard advance, FSM state and sticky memory-timeout tracking.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= RUN;
            ent_e_r    <= EMPTY_ENT;
            ent_m_r    <= EMPTY_ENT;
            ent_w_r    <= EMPTY_ENT;
            wait_cnt_r <= {WAIT_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (mem_stall_s) begin
                ent_w_r <= EMPTY_ENT;
                if (wait_cnt_r != WAIT_MAX) begin
                    wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
                // The first stalled cycle counts as the first wait cycle.
                if (wait_cnt_r >= WAIT_LAST) begin
                    err_r <= 1'b1;
                end else begin
                    err_r <= err_r;
                end
            end else begin
                ent_w_r    <= ent_m_r;
                ent_m_r    <= retire_operands(ent_e_r);
                ent_e_r    <= flush_e_s ? EMPTY_ENT : id_ent_s;
                wait_cnt_r <= {WAIT_W{1'b0}};
            end
        end
    end

    assign StallF      = stall_f_s && !RST;
    assign StallD      = stall_d_s && !RST;
    assign StallE      = stall_e_s && !RST;
    assign StallM      = stall_m_s && !RST;
    assign FlushD      = flush_d_s && !RST;
    assign FlushE      = flush_e_s && !RST;
    assign FlushW      = flush_w_s && !RST;
    assign ForwardAE   = RST ? 2'b00 : fwd_a_s;
    assign ForwardBE   = RST ? 2'b00 : fwd_b_s;
    assign err_timeout = err_r && !RST;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] memwait_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic hit);
        logic [CNT_W-1:0] nxt;
        if (hit && (cnt != {CNT_W{1'b1}})) begin
            nxt = cnt + CNT_W'(1);
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    // Saturating event counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_r   <= {CNT_W{1'b0}};
            flush_cnt_r   <= {CNT_W{1'b0}};
            memwait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r   <= sat_inc(stall_cnt_r, stall_d_s);
            flush_cnt_r   <= sat_inc(flush_cnt_r, flush_d_s || flush_e_s);
            memwait_cnt_r <= sat_inc(memwait_cnt_r, mem_stall_s);
        end
    end

    assign stall_cnt   = RST ? {CNT_W{1'b0}} : stall_cnt_r;
    assign flush_cnt   = RST ? {CNT_W{1'b0}} : flush_cnt_r;
    assign memwait_cnt = RST ? {CNT_W{1'b0}} : memwait_cnt_r;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle memory-wait sequences,
// and randomized stimulus against a stage-array reference model.
module tb_hazard_ctrl;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] rs_addrD, rt_addrD, dest_addrD;
    logic       useRsD, useRtD, RegWriteD, MemtoRegD, MemAccessD, JumpD, BranchTakenE, mem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, err_timeout;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

    always #5 CLK = ~CLK;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .rs_addrD(rs_addrD), .rt_addrD(rt_addrD), .useRsD(useRsD), .useRtD(useRtD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemAccessD(MemAccessD),
        .dest_addrD(dest_addrD), .JumpD(JumpD), .BranchTakenE(BranchTakenE), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .err_timeout(err_timeout)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       rw;
        logic       mtr;
        logic       ma;
        logic [4:0] dest;
        logic       jmp;
        logic       br;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t         i;
        logic [11:0] e;
    } vec_t;

    // Observed vector: {StallF,StallD,StallE,StallM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE, err}
    localparam logic [11:0] E_ZERO = 12'b0000_000_00_00_0;
    localparam logic [11:0] E_LU   = 12'b1100_010_00_00_0;
    localparam logic [11:0] E_BR   = 12'b0000_110_00_00_0;
    localparam logic [11:0] E_JMP  = 12'b0000_100_00_00_0;
    localparam logic [11:0] E_MW   = 12'b1111_001_00_00_0;
    localparam logic [11:0] E_ERR  = 12'b0000_000_00_00_1;
    localparam logic [11:0] E_FA10 = 12'b0000_000_10_00_0;
    localparam logic [11:0] E_FA01 = 12'b0000_000_01_00_0;
    localparam logic [11:0] E_FB10 = 12'b0000_000_00_10_0;
    localparam logic [11:0] E_FB01 = 12'b0000_000_00_01_0;

    logic [11:0] act;
    assign act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, err_timeout};

    int checks = 0;
    int errors = 0;

    function automatic in_t ins(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                input logic urt, input logic rw, input logic mtr, input logic ma,
                                input logic [4:0] dest);
        in_t t;
        t      = '0;
        t.rs   = rs;
        t.rt   = rt;
        t.urs  = urs;
        t.urt  = urt;
        t.rw   = rw;
        t.mtr  = mtr;
        t.ma   = ma;
        t.dest = dest;
        t.rdy  = 1'b1;
        return t;
    endfunction

    task automatic apply(input in_t i);
        RST          = i.rst;
        rs_addrD     = i.rs;
        rt_addrD     = i.rt;
        useRsD       = i.urs;
        useRtD       = i.urt;
        RegWriteD    = i.rw;
        MemtoRegD    = i.mtr;
        MemAccessD   = i.ma;
        dest_addrD   = i.dest;
        JumpD        = i.jmp;
        BranchTakenE = i.br;
        mem_ready    = i.rdy;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Drive one cycle just after a rising edge, compare on the falling edge.
    task automatic cyc(input in_t i, input logic [11:0] exp, input string name);
        apply(i);
        @(negedge CLK);
        check(name, exp);
        @(posedge CLK);
        #1;
    endtask

    // Reference model: three pipeline slots, next to each other in an array-like trio.
    typedef struct {
        bit       v, rw, mtr, ma;
        bit [4:0] d, rs, rt;
    } ment_t;

    ment_t me, mm, mw;
    int    waitn;
    bit    merr;

    function automatic bit supplies(input ment_t x, input bit [4:0] a);
        return x.v && x.rw && (x.d != 5'd0) && (x.d == a);
    endfunction

    function automatic bit [1:0] src_for(input bit [4:0] a);
        if (supplies(mm, a)) return 2'b10;
        if (supplies(mw, a)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        me = '{default: 0};
        mm = '{default: 0};
        mw = '{default: 0};
        waitn = 0;
        merr  = 1'b0;
    endtask

    task automatic model_step(input in_t i, output logic [11:0] exp);
        bit sf, sd, se, sm, fd, fe, fw, memst, lu;
        ment_t nw;
        {sf, sd, se, sm, fd, fe, fw} = 7'b0;
        memst = mm.v && mm.ma && !i.rdy;
        lu    = me.v && me.mtr && (me.d != 5'd0) &&
                ((i.urs && i.rs == me.d) || (i.urt && i.rt == me.d));
        if (memst) {sf, sd, se, sm, fw} = 5'b11111;
        else if (i.br) {fd, fe} = 2'b11;
        else if (lu) {sf, sd, fe} = 3'b111;
        else if (i.jmp) fd = 1'b1;
        exp = i.rst ? 12'b0 : {sf, sd, se, sm, fd, fe, fw, src_for(me.rs), src_for(me.rt), merr};
        if (i.rst) begin
            model_reset();
        end else if (memst) begin
            waitn++;
            if (waitn >= MEM_TIMEOUT) merr = 1'b1;
            mw = '{default: 0};
        end else begin
            waitn = 0;
            mw = mm;
            mm = me;
            nw = '{v: 1'b1, rw: i.rw, mtr: i.mtr, ma: i.ma, d: i.dest, rs: i.rs, rt: i.rt};
            me = fe ? '{default: 0} : nw;
        end
    endtask

    vec_t tbl[20];
    in_t  rst_i, nop_i, sw_i, t;
    logic [11:0] e;

    initial begin
        nop_i = ins(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        rst_i = nop_i;
        rst_i.rst = 1'b1;
        sw_i  = ins(5'd29, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0);

        tbl[0]  = '{rst_i, E_ZERO};
        tbl[1]  = '{ins(5'd29, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8), E_ZERO};   // lw $8
        tbl[2]  = '{ins(5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9), E_LU};    // add $9,$8 load-use
        tbl[3]  = '{ins(5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd9), E_ZERO};  // lw in M: 00
        tbl[4]  = '{ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5), E_FA01};   // lw in W: 01
        tbl[5]  = '{ins(5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5), E_ZERO};
        tbl[6]  = '{ins(5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7), E_FB10};   // rt=5 from M
        tbl[7]  = '{ins(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0), E_FA10};   // $5 in M and W
        tbl[8]  = '{ins(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6), E_ZERO};
        tbl[9]  = '{nop_i, E_ZERO};                                                 // M writes r0, rt=0
        tbl[10] = '{nop_i, E_BR};
        tbl[10].i.br  = 1'b1;
        tbl[10].i.jmp = 1'b1;
        tbl[11] = '{ins(5'd29, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12), E_ZERO}; // lw $12
        tbl[12] = '{ins(5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd13), E_BR};   // branch beats load-use
        tbl[12].i.br = 1'b1;
        tbl[13] = '{nop_i, E_ZERO};                                                 // lw in M, ready
        tbl[14] = '{nop_i, E_JMP};
        tbl[14].i.jmp = 1'b1;
        tbl[15] = '{ins(5'd12, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0), E_ZERO};
        tbl[16] = '{ins(5'd29, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd14), E_ZERO}; // lw $14
        tbl[17] = '{ins(5'd3, 5'd14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd15), E_LU};   // load-use via rt
        tbl[18] = '{ins(5'd3, 5'd14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd15), E_ZERO};
        tbl[19] = '{nop_i, E_FB01};

        apply(rst_i);
        @(posedge CLK);
        #1;

        for (int k = 0; k < 20; k++) cyc(tbl[k].i, tbl[k].e, $sformatf("tbl%0d", k));

        // Store stalls for three cycles; a branch during the wait is suppressed.
        cyc(rst_i, E_ZERO, "mw_rst");
        cyc(sw_i, E_ZERO, "mw_swD");
        cyc(nop_i, E_ZERO, "mw_swE");
        t = nop_i;
        t.rdy = 1'b0;
        t.br  = 1'b1;
        cyc(t, E_MW, "mw_w1");
        t.br = 1'b0;
        cyc(t, E_MW, "mw_w2");
        cyc(t, E_MW, "mw_w3");
        cyc(nop_i, E_ZERO, "mw_done");
        cyc(t, E_ZERO, "mw_after");

        // Twenty-cycle wait crosses the timeout; the error stays until reset.
        cyc(rst_i, E_ZERO, "to_rst");
        cyc(sw_i, E_ZERO, "to_swD");
        cyc(nop_i, E_ZERO, "to_swE");
        for (int n = 1; n <= 20; n++)
            cyc(t, (n > MEM_TIMEOUT) ? (E_MW | E_ERR) : E_MW, $sformatf("to_w%0d", n));
        cyc(nop_i, E_ERR, "to_ready");
        cyc(nop_i, E_ERR, "to_sticky");
        cyc(rst_i, E_ZERO, "to_clr");
        cyc(nop_i, E_ZERO, "to_cleared");

        // Reset in the middle of a wait empties everything.
        cyc(sw_i, E_ZERO, "rw_swD");
        cyc(nop_i, E_ZERO, "rw_swE");
        cyc(t, E_MW, "rw_w1");
        cyc(t, E_MW, "rw_w2");
        t.rst = 1'b1;
        cyc(t, E_ZERO, "rw_rst");
        t.rst = 1'b0;
        apply(t);
        @(negedge CLK);
        check("rw_after", E_ZERO);
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || memwait_cnt !== '0) begin
            errors++;
            $display("FAIL stats_clr got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, memwait_cnt);
        end
`endif
        @(posedge CLK);
        #1;

        // Randomized traffic over a small register set against the model.
        model_reset();
        cyc(rst_i, E_ZERO, "rand_rst");
        for (int k = 0; k < 3000; k++) begin
            t.rst  = ($urandom_range(0, 149) == 0);
            t.rs   = 5'($urandom_range(0, 3));
            t.rt   = 5'($urandom_range(0, 3));
            t.dest = 5'($urandom_range(0, 3));
            t.urs  = 1'($urandom_range(0, 1));
            t.urt  = 1'($urandom_range(0, 1));
            t.rw   = 1'($urandom_range(0, 1));
            t.mtr  = 1'($urandom_range(0, 1));
            t.ma   = t.mtr | 1'($urandom_range(0, 1));
            t.jmp  = ($urandom_range(0, 5) == 0);
            t.br   = ($urandom_range(0, 7) == 0);
            t.rdy  = ($urandom_range(0, 3) != 0);
            model_step(t, e);
            cyc(t, e, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
